sign_extension: RTL and testbench

SIGN_EXTENSION -- requirements
Module: sign_extension

---
 rtl/sign_extension.sv | 84 ++++++++
 tb/tb_sign_extension.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sign_extension.sv
// Immediate extender: combinational y/neg from a/mode, plus a registered
// copy y_q qualified by in_valid with a one-cycle out_valid strobe.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   a [IN_W-1:0]    immediate field
//   mode [2:0]      000 hw sext, 001 hw zext, 010 byte sext, 011 byte zext,
//                   100 upper imm, 101 branch offset (sext << 2), 11x = 000
//   in_valid        capture y into y_q on this edge
//   y [OUT_W-1:0]   combinational result, neg = y[OUT_W-1]
//   y_q, out_valid  registered result and its one-cycle valid
module sign_extension #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  a,
  input  logic [2:0]       mode,
  input  logic             in_valid,
  output logic [OUT_W-1:0] y,
  output logic             neg,
  output logic [OUT_W-1:0] y_q,
  output logic             out_valid
);

  localparam int PAD_W = OUT_W - IN_W;
  localparam int BYTE_PAD_W = OUT_W - 8;

  logic [OUT_W-1:0] hw_sext;
  logic [OUT_W-1:0] hw_zext;
  logic [OUT_W-1:0] b_sext;
  logic [OUT_W-1:0] b_zext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] branch;

  assign hw_sext = {{PAD_W{a[IN_W-1]}}, a};
  assign hw_zext = {{PAD_W{1'b0}}, a};
  assign b_sext  = {{BYTE_PAD_W{a[7]}}, a[7:0]};
  assign b_zext  = {{BYTE_PAD_W{1'b0}}, a[7:0]};
  assign upper   = {a, {PAD_W{1'b0}}};
  // Word-aligned offset: top two sign bits fall off the end.
  assign branch  = {hw_sext[OUT_W-3:0], 2'b00};

  always_comb begin
    y = hw_sext;
    unique case (mode)
      3'b001:  y = hw_zext;
      3'b010:  y = b_sext;
      3'b011:  y = b_zext;
      3'b100:  y = upper;
      3'b101:  y = branch;
      default: y = hw_sext;
    endcase
  end

  assign neg = y[OUT_W-1];

  logic [OUT_W-1:0] y_d;
  logic [OUT_W-1:0] y_r_q;
  logic             out_valid_d;
  logic             out_valid_q;

  always_comb begin
    y_d         = y_r_q;
    out_valid_d = 1'b0;
    if (reset) begin
      y_d         = '0;
      out_valid_d = 1'b0;
    end else if (in_valid) begin
      y_d         = y;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    y_r_q       <= y_d;
    out_valid_q <= out_valid_d;
  end

  assign y_q       = y_r_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_extension.sv
// Bench for sign_extension: vector table, directed register sequences,
// and randomized cycles against an arithmetic reference model.
module tb_sign_extension;

  logic        clk;
  logic        reset;
  logic [15:0] a;
  logic [2:0]  mode;
  logic        in_valid;
  logic [31:0] y;
  logic        neg;
  logic [31:0] y_q;
  logic        out_valid;

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_yq;
  logic        exp_ov;

  sign_extension #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .a(a),
    .mode(mode),
    .in_valid(in_valid),
    .y(y),
    .neg(neg),
    .y_q(y_q),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] aa,
                                        input logic [2:0] m);
    int v;
    case (m)
      3'd1:    v = int'(aa);
      3'd2:    v = int'(byte'(aa[7:0]));
      3'd3:    v = int'(aa) % 256;
      3'd4:    v = int'(aa) * 65536;
      3'd5:    v = int'(shortint'(aa)) * 4;
      default: v = int'(shortint'(aa));
    endcase
    return 32'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Apply inputs for one cycle, check comb outputs, then registered outputs.
  task automatic cycle(input logic r, input logic v,
                       input logic [15:0] aa, input logic [2:0] m);
    logic [31:0] e;
    reset = r; in_valid = v; a = aa; mode = m;
    e = model(aa, m);
    #1;
    chk("y", y, e);
    chk("neg", {31'b0, neg}, {31'b0, e[31]});
    @(posedge clk);
    if (r) begin
      exp_yq = 32'h0; exp_ov = 1'b0;
    end else if (v) begin
      exp_yq = e; exp_ov = 1'b1;
    end else begin
      exp_ov = 1'b0;
    end
    #1;
    chk("y_q", y_q, exp_yq);
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
  endtask

  typedef struct {
    logic [15:0] a;
    logic [2:0]  mode;
    logic [31:0] y;
    logic        neg;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{16'h8000, 3'b000, 32'hFFFF8000, 1'b1};
    vecs[1]  = '{16'h7FFF, 3'b000, 32'h00007FFF, 1'b0};
    vecs[2]  = '{16'hFFFF, 3'b000, 32'hFFFFFFFF, 1'b1};
    vecs[3]  = '{16'h0000, 3'b000, 32'h00000000, 1'b0};
    vecs[4]  = '{16'h8080, 3'b001, 32'h00008080, 1'b0};
    vecs[5]  = '{16'h8080, 3'b010, 32'hFFFFFF80, 1'b1};
    vecs[6]  = '{16'h8080, 3'b011, 32'h00000080, 1'b0};
    vecs[7]  = '{16'h8080, 3'b100, 32'h80800000, 1'b1};
    vecs[8]  = '{16'h8080, 3'b101, 32'hFFFE0200, 1'b1};
    vecs[9]  = '{16'h8001, 3'b110, 32'hFFFF8001, 1'b1};
    vecs[10] = '{16'h8001, 3'b111, 32'hFFFF8001, 1'b1};
    vecs[11] = '{16'h407F, 3'b010, 32'h0000007F, 1'b0};

    exp_yq = 32'h0;
    exp_ov = 1'b0;
    reset = 1'b1; in_valid = 1'b0; a = 16'h0; mode = 3'b000;

    // Reset state
    cycle(1'b1, 1'b0, 16'h0, 3'b000);
    chk("rst_yq", y_q, 32'h0);
    chk("rst_ov", {31'b0, out_valid}, 32'h0);

    // Combinational vectors with reset held high: y must not care
    for (int i = 0; i < 12; i++) begin
      reset = 1'b1; in_valid = 1'b1;
      a = vecs[i].a; mode = vecs[i].mode;
      #1;
      chk($sformatf("vec%0d_y", i), y, vecs[i].y);
      chk($sformatf("vec%0d_neg", i), {31'b0, neg}, {31'b0, vecs[i].neg});
      @(posedge clk);
      #1;
    end

    // Reset wins over in_valid, then first capture after release
    cycle(1'b1, 1'b1, 16'h1234, 3'b000);
    chk("r_pri_yq", y_q, 32'h0);
    chk("r_pri_ov", {31'b0, out_valid}, 32'h0);
    cycle(1'b0, 1'b1, 16'h1234, 3'b000);
    chk("post_r_yq", y_q, 32'h00001234);
    chk("post_r_ov", {31'b0, out_valid}, 32'h1);

    // Three back-to-back then idle: y_q holds the third
    cycle(1'b0, 1'b1, 16'h0011, 3'b001);
    chk("s1_ov", {31'b0, out_valid}, 32'h1);
    cycle(1'b0, 1'b1, 16'h8080, 3'b101);
    chk("s2_ov", {31'b0, out_valid}, 32'h1);
    cycle(1'b0, 1'b1, 16'h00F0, 3'b010);
    chk("s3_ov", {31'b0, out_valid}, 32'h1);
    chk("s3_yq", y_q, 32'hFFFFFFF0);
    cycle(1'b0, 1'b0, 16'hAAAA, 3'b100);
    chk("idle_ov", {31'b0, out_valid}, 32'h0);
    chk("idle_yq", y_q, 32'hFFFFFFF0);

    // Reset mid-stream discards the capture on that edge
    cycle(1'b0, 1'b1, 16'h5555, 3'b000);
    cycle(1'b1, 1'b1, 16'h6666, 3'b000);
    chk("mid_r_yq", y_q, 32'h0);
    cycle(1'b0, 1'b1, 16'h00FF, 3'b011);
    chk("mid_post_yq", y_q, 32'h000000FF);

    // Randomized cycles
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 19) == 0), 1'($urandom),
            16'($urandom), 3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
